hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
// State codes and the default register-specifier width live here.
package hazard_pkg;

    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        ISTALL = 2'd2,
        DSTALL = 2'd3
    } state_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } wren_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } clr_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination is a live
// source of the instruction in ID. Register 0 never hazards.
module hazard_detect import hazard_pkg::*; #(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
) (
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic                  id_rs_used,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rt_used,
    output logic                  load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_rs_used && (id_rs == ex_rd);
    assign rt_hit   = id_rt_used && (id_rt == ex_rd);
    assign load_use = ex_memread && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: Mealy enables from the winning
// event, registered state and a saturating stall counter.
module hazard_ctrl import hazard_pkg::*; #(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  br_taken,
    input  logic                  imem_busy,
    input  logic                  dmem_busy,
    output logic                  pc_wren,
    output logic                  ifid_wren,
    output logic                  idex_wren,
    output logic                  exmem_wren,
    output logic                  memwb_wren,
    output logic                  ifid_clr,
    output logic                  idex_clr,
    output logic                  exmem_clr,
    output logic                  memwb_clr,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  stall_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state_q;
    state_t          state_d;
    logic [CNT_W-1:0] cnt_q;
    logic            load_use;
    wren_t           wren;
    clr_t            clr;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rt      (id_rt),
        .id_rt_used (id_rt_used),
        .load_use   (load_use)
    );

    // Each state only persists while its own event still wins,
    // so the next state is purely the current winning event.
    always_comb begin
        state_d = RUN;
        wren    = '1;
        clr     = '0;
        priority case (1'b1)
            dmem_busy: begin
                state_d = DSTALL;
                wren    = 5'b00001;
                clr     = 4'b0001;
            end
            br_taken: begin
                state_d = RUN;
                clr     = 4'b1100;
            end
            imem_busy: begin
                state_d = ISTALL;
                wren    = 5'b01111;
                clr     = 4'b1000;
            end
            load_use: begin
                state_d = LDUSE;
                wren    = 5'b00111;
                clr     = 4'b0100;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (rst) begin
            wren = '0;
            clr  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == RUN)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pc_wren       = wren.pc;
    assign ifid_wren     = wren.ifid;
    assign idex_wren     = wren.idex;
    assign exmem_wren    = wren.exmem;
    assign memwb_wren    = wren.memwb;
    assign ifid_clr      = clr.ifid;
    assign idex_clr      = clr.idex;
    assign exmem_clr     = clr.exmem;
    assign memwb_clr     = clr.memwb;
    assign state         = state_q;
    assign stall_cnt     = cnt_q;
    assign stall_timeout = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: default-width and 2-bit
// counter instances driven in lockstep.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic       id_rs_used, id_rt_used, ex_memread;
    logic       br_taken, imem_busy, dmem_busy;

    logic       pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren;
    logic       ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic [1:0] state;
    logic [7:0] stall_cnt;
    logic       stall_timeout;

    logic       s_pc_wren, s_ifid_wren, s_idex_wren, s_exmem_wren;
    logic       s_memwb_wren, s_ifid_clr, s_idex_clr, s_exmem_clr;
    logic       s_memwb_clr;
    logic [1:0] s_state;
    logic [1:0] s_stall_cnt;
    logic       s_stall_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [8:0] ec;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       to;
        logic [1:0] cnt2;
        logic       to2;
    } exp_t;

    exp_t sb[$];

    logic [1:0] m_st;
    logic [7:0] m_cnt;
    logic [1:0] m_cnt2;

    hazard_ctrl u_dut (
        .clk (clk), .rst (rst),
        .id_rs (id_rs), .id_rt (id_rt),
        .id_rs_used (id_rs_used), .id_rt_used (id_rt_used),
        .ex_memread (ex_memread), .ex_rd (ex_rd),
        .br_taken (br_taken), .imem_busy (imem_busy),
        .dmem_busy (dmem_busy),
        .pc_wren (pc_wren), .ifid_wren (ifid_wren),
        .idex_wren (idex_wren), .exmem_wren (exmem_wren),
        .memwb_wren (memwb_wren),
        .ifid_clr (ifid_clr), .idex_clr (idex_clr),
        .exmem_clr (exmem_clr), .memwb_clr (memwb_clr),
        .state (state), .stall_cnt (stall_cnt),
        .stall_timeout (stall_timeout)
    );

    hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk (clk), .rst (rst),
        .id_rs (id_rs), .id_rt (id_rt),
        .id_rs_used (id_rs_used), .id_rt_used (id_rt_used),
        .ex_memread (ex_memread), .ex_rd (ex_rd),
        .br_taken (br_taken), .imem_busy (imem_busy),
        .dmem_busy (dmem_busy),
        .pc_wren (s_pc_wren), .ifid_wren (s_ifid_wren),
        .idex_wren (s_idex_wren), .exmem_wren (s_exmem_wren),
        .memwb_wren (s_memwb_wren),
        .ifid_clr (s_ifid_clr), .idex_clr (s_idex_clr),
        .exmem_clr (s_exmem_clr), .memwb_clr (s_memwb_clr),
        .state (s_state), .stall_cnt (s_stall_cnt),
        .stall_timeout (s_stall_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference priority decode: {pc,ifid,idex,exmem,memwb wren,
    // ifid,idex,exmem,memwb clr} and the state it leads to.
    task automatic predict(output logic [8:0] ec, output logic [1:0] ns);
        logic lu;
        lu = ex_memread && ex_rd != 0 &&
             ((id_rs_used && id_rs == ex_rd) ||
              (id_rt_used && id_rt == ex_rd));
        if (dmem_busy) begin
            ec = 9'b00001_0001; ns = 2'd3;
        end else if (br_taken) begin
            ec = 9'b11111_1100; ns = 2'd0;
        end else if (imem_busy) begin
            ec = 9'b01111_1000; ns = 2'd2;
        end else if (lu) begin
            ec = 9'b00111_0100; ns = 2'd1;
        end else begin
            ec = 9'b11111_0000; ns = 2'd0;
        end
        if (rst) ec = '0;
    endtask

    task automatic step();
        exp_t       e;
        exp_t       o;
        logic [8:0] ec;
        logic [1:0] ns;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_cnt2 = 0;
        end
        predict(ec, ns);
        e.ec   = ec;
        e.st   = m_st;
        e.cnt  = m_cnt;
        e.to   = (m_cnt == 8'hff);
        e.cnt2 = m_cnt2;
        e.to2  = (m_cnt2 == 2'd3);
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        chk("enables", {pc_wren, ifid_wren, idex_wren, exmem_wren,
                        memwb_wren, ifid_clr, idex_clr, exmem_clr,
                        memwb_clr}, o.ec);
        chk("sat_enables", {s_pc_wren, s_ifid_wren, s_idex_wren,
                            s_exmem_wren, s_memwb_wren, s_ifid_clr,
                            s_idex_clr, s_exmem_clr, s_memwb_clr}, o.ec);
        chk("state", state, o.st);
        chk("stall_cnt", stall_cnt, o.cnt);
        chk("timeout", stall_timeout, o.to);
        chk("sat_cnt", s_stall_cnt, o.cnt2);
        chk("sat_timeout", s_stall_timeout, o.to2);
        @(posedge clk);
        if (rst) begin
            m_st = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_st = ns;
            if (ns == 0) begin
                m_cnt = 0; m_cnt2 = 0;
            end else begin
                if (m_cnt != 8'hff) m_cnt++;
                if (m_cnt2 != 2'd3) m_cnt2++;
            end
        end
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_rs_used = 0; id_rt_used = 0; ex_memread = 0;
        br_taken = 0; imem_busy = 0; dmem_busy = 0;
    endtask

    task automatic set_lu(input logic [3:0] rd);
        ex_memread = 1; ex_rd = rd; id_rs = 4'd3; id_rs_used = 1;
    endtask

    initial begin
        m_st = 0; m_cnt = 0; m_cnt2 = 0;
        idle();
        rst = 1;
        #1;
        step();
        step();
        rst = 0;
        step();

        // load-use on rs, then clear
        set_lu(4'd3);
        step();
        idle();
        chk("ldu_state", state, 2'd1);
        step();
        step();
        chk("ldu_cnt_clr", stall_cnt, 8'd0);

        // r0 destination never hazards
        set_lu(4'd0);
        step();
        step();

        // load-use on rt only
        idle();
        ex_memread = 1; ex_rd = 4'd5; id_rt = 4'd5; id_rt_used = 1;
        step();
        id_rt_used = 0;
        step();

        // taken branch squashes the load-use victim
        idle();
        set_lu(4'd3);
        br_taken = 1;
        step();
        chk("br_state", state, 2'd0);

        // dmem stall with a pending branch, then release
        idle();
        dmem_busy = 1; br_taken = 1;
        repeat (5) step();
        chk("dstall_cnt", stall_cnt, 8'd5);
        dmem_busy = 0;
        step();
        idle();
        step();

        // imem stall long enough to saturate the narrow counter
        imem_busy = 1;
        repeat (6) step();
        chk("sat_hold", s_stall_cnt, 2'd3);
        imem_busy = 0;
        step();
        step();

        // reset pulse mid data stall
        dmem_busy = 1;
        repeat (3) step();
        rst = 1;
        step();
        rst = 0;
        step();
        step();
        idle();
        step();

        // randomized mix with occasional reset
        for (int i = 0; i < 400; i++) begin
            id_rs      = 4'($urandom_range(0, 3));
            id_rt      = 4'($urandom_range(0, 3));
            ex_rd      = 4'($urandom_range(0, 3));
            id_rs_used = 1'($urandom_range(0, 1));
            id_rt_used = 1'($urandom_range(0, 1));
            ex_memread = 1'($urandom_range(0, 1));
            br_taken   = ($urandom_range(0, 5) == 0);
            imem_busy  = ($urandom_range(0, 4) == 0);
            dmem_busy  = ($urandom_range(0, 5) == 0);
            rst        = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
